// File: rtl/pll_sup_pkg.sv
// Shared types and helpers for the PLL lock supervisor.
// Holds the sequencer state encoding and the cycle-counter sizing rule.
package pll_sup_pkg;

  typedef enum logic [1:0] {
    RESET_PLL = 2'd0,
    WAIT_LOCK = 2'd1,
    STABILIZE = 2'd2,
    RUN       = 2'd3
  } pll_state_e;

  // Wide enough for the largest interval, with one bit of headroom.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/pll_lock_supervisor_sync_2ff.sv
// Single-bit two-flop synchronizer with asynchronous active-high clear.
// Shared by the clock-domain-crossing logic in this codebase.
module sync_2ff (
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic q
);

  logic meta_r;

  // First flop may go metastable; the second gives it a full cycle to settle.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      meta_r <= 1'b0;
      q      <= 1'b0;
    end else begin
      meta_r <= d;
      q      <= meta_r;
    end
  end

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencer: pulses the PLL reset, waits for a debounced lock and
// only then releases the downstream system reset; re-runs on lock loss or request.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int RST_PULSE_CYCLES    = 10,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int STABLE_CYCLES       = 1024,
  parameter int RELOCK_CNT_W        = 8
) (
  input  logic                    refclk,
  input  logic                    rst,
  input  logic                    locked,
  input  logic                    force_relock,
  output logic                    pll_rst,
  output logic                    sys_rst,
  output logic                    pll_ok,
  output logic                    timeout_err,
  output logic [RELOCK_CNT_W-1:0] relock_cnt
);

  localparam int CW = cnt_width(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, STABLE_CYCLES);

  // The counter holds edges already spent in the state, so the K-th edge sees K-1.
  localparam logic [CW-1:0] RST_LAST    = CW'(RST_PULSE_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [RELOCK_CNT_W-1:0] RELOCK_MAX = {RELOCK_CNT_W{1'b1}};

  pll_state_e              state_r;
  pll_state_e              state_n;
  logic [CW-1:0]           cnt_r;
  logic [CW-1:0]           cnt_n;
  logic                    timeout_n;
  logic [RELOCK_CNT_W-1:0] relock_n;
  logic                    locked_s;

  sync_2ff u_lock_sync (
    .clk (refclk),
    .clr (rst),
    .d   (locked),
    .q   (locked_s)
  );

  // Next-state, counter and flag computation.
  always_comb begin
    state_n   = state_r;
    timeout_n = timeout_err;
    relock_n  = relock_cnt;
    cnt_n     = cnt_r;
    case (state_r)
      RESET_PLL: begin
        if (cnt_r == RST_LAST) begin
          state_n = WAIT_LOCK;
        end else begin
          state_n = RESET_PLL;
        end
      end
      WAIT_LOCK: begin
        if (locked_s) begin
          state_n = STABILIZE;
        end else if (cnt_r == TIMEOUT_LAST) begin
          state_n   = RESET_PLL;
          timeout_n = 1'b1;
        end else begin
          state_n = WAIT_LOCK;
        end
      end
      STABILIZE: begin
        // A lock drop outranks the terminal count on the same edge.
        if (!locked_s) begin
          state_n = WAIT_LOCK;
        end else if (cnt_r == STABLE_LAST) begin
          state_n   = RUN;
          timeout_n = 1'b0;
        end else begin
          state_n = STABILIZE;
        end
      end
      RUN: begin
        if (!locked_s || force_relock) begin
          state_n = RESET_PLL;
          if (relock_cnt != RELOCK_MAX) begin
            relock_n = relock_cnt + RELOCK_CNT_W'(1);
          end else begin
            relock_n = relock_cnt;
          end
        end else begin
          state_n = RUN;
        end
      end
      default: begin
        state_n = RESET_PLL;
      end
    endcase
    if (state_n != state_r) begin
      cnt_n = {CW{1'b0}};
    end else if (state_r != RUN) begin
      cnt_n = cnt_r + CW'(1);
    end else begin
      cnt_n = cnt_r;
    end
  end

  // State, counter and outputs all update on the same edge from the next state.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_r     <= RESET_PLL;
      cnt_r       <= {CW{1'b0}};
      pll_rst     <= 1'b1;
      sys_rst     <= 1'b1;
      pll_ok      <= 1'b0;
      timeout_err <= 1'b0;
      relock_cnt  <= {RELOCK_CNT_W{1'b0}};
    end else begin
      state_r     <= state_n;
      cnt_r       <= cnt_n;
      pll_rst     <= (state_n == RESET_PLL);
      sys_rst     <= (state_n != RUN);
      pll_ok      <= (state_n == RUN);
      timeout_err <= timeout_n;
      relock_cnt  <= relock_n;
    end
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Randomized and directed bench for pll_lock_supervisor against a
// phase/elapsed-edge reference model of the sequencing rules.
module tb_pll_lock_supervisor;

  localparam int RP = 4;
  localparam int TO = 20;
  localparam int ST = 8;
  localparam int M_RST = 0, M_WAIT = 1, M_STAB = 2, M_RUN = 3;

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       locked = 1'b0;
  logic       force_relock = 1'b0;
  logic       pll_rst, sys_rst, pll_ok, timeout_err;
  logic [7:0] relock_cnt;

  int chk_cnt = 0;
  int err_cnt = 0;

  // Reference model state
  int m_ph, m_el, m_rel;
  bit m_tout, h1, h2;

  pll_lock_supervisor #(
    .RST_PULSE_CYCLES    (RP),
    .LOCK_TIMEOUT_CYCLES (TO),
    .STABLE_CYCLES       (ST),
    .RELOCK_CNT_W        (8)
  ) dut (
    .refclk       (refclk),
    .rst          (rst),
    .locked       (locked),
    .force_relock (force_relock),
    .pll_rst      (pll_rst),
    .sys_rst      (sys_rst),
    .pll_ok       (pll_ok),
    .timeout_err  (timeout_err),
    .relock_cnt   (relock_cnt)
  );

  always #5 refclk = ~refclk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ph = M_RST; m_el = 0; m_rel = 0; m_tout = 0; h1 = 0; h2 = 0;
  endtask

  task automatic go(input int ph);
    m_ph = ph; m_el = 0;
  endtask

  // One refclk edge of the supervisor's rules, as seen through a 2-cycle lock delay.
  task automatic model_step();
    bit ls;
    if (rst) begin
      model_reset();
    end else begin
      ls = h2; h2 = h1; h1 = locked;
      m_el++;
      case (m_ph)
        M_RST:  if (m_el == RP) go(M_WAIT);
        M_WAIT: if (ls) go(M_STAB);
                else if (m_el == TO) begin m_tout = 1; go(M_RST); end
        M_STAB: if (!ls) go(M_WAIT);
                else if (m_el == ST) begin m_tout = 0; go(M_RUN); end
        default: if (!ls || force_relock) begin
                   if (m_rel < 255) m_rel++;
                   go(M_RST);
                 end
      endcase
    end
  endtask

  task automatic check_outputs();
    check_eq("pll_rst", pll_rst, (m_ph == M_RST));
    check_eq("sys_rst", sys_rst, (m_ph != M_RUN));
    check_eq("pll_ok", pll_ok, (m_ph == M_RUN));
    check_eq("timeout_err", timeout_err, m_tout);
    check_eq("relock_cnt", relock_cnt, m_rel);
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge refclk);
      model_step();
      #1;
      check_outputs();
    end
  endtask

  task automatic wait_run(input int limit);
    int n;
    n = 0;
    while (pll_ok !== 1'b1 && n < limit) begin cyc(1); n++; end
    check_eq("reach_run", pll_ok, 1);
  endtask

  task automatic wait_phase(input int ph, input int limit);
    int n;
    n = 0;
    while (m_ph != ph && n < limit) begin cyc(1); n++; end
    check_eq("reach_phase", m_ph, ph);
  endtask

  task automatic relock_pulse();
    force_relock = 1'b1; cyc(1); force_relock = 1'b0;
  endtask

  initial begin
    int n, ones, rc_before;
    bit seen;
    model_reset();
    #2;
    cyc(3);
    check_eq("reset_pll_rst", pll_rst, 1);
    check_eq("reset_relock", relock_cnt, 0);

    // Lock-up
    rst = 1'b0;
    n = 0;
    do begin cyc(1); n++; end while (pll_rst === 1'b1 && n < 50);
    check_eq("pll_rst_pulse_len", n, RP);
    cyc(9);
    locked = 1'b1;
    n = 0;
    do begin cyc(1); n++; end while (sys_rst === 1'b1 && n < 100);
    check_eq("lock_latency", n, 2 + ST + 1);
    check_eq("lockup_pll_ok", pll_ok, 1);
    check_eq("lockup_relock", relock_cnt, 0);

    // Single-cycle lock loss in RUN
    cyc(3);
    locked = 1'b0; cyc(1);
    locked = 1'b1; cyc(1);
    check_eq("loss_n1_sys_rst", sys_rst, 0);
    cyc(1);
    check_eq("loss_n2_sys_rst", sys_rst, 1);
    check_eq("loss_n2_pll_rst", pll_rst, 1);
    check_eq("loss_relock", relock_cnt, 1);
    wait_run(100);

    // Never lock: timeout then periodic PLL reset pulses
    locked = 1'b0;
    n = 0;
    do begin cyc(1); n++; end while (timeout_err !== 1'b1 && n < 200);
    check_eq("timeout_edge", n, 27);
    ones = 0;
    for (int i = 0; i < 48; i++) begin cyc(1); ones += int'(pll_rst); end
    check_eq("repulse_count", ones, 2 * RP);
    check_eq("timeout_relock", relock_cnt, 2);
    locked = 1'b1;
    wait_run(200);
    check_eq("timeout_cleared", timeout_err, 0);

    // Lock glitch in STABILIZE, drop coinciding with the terminal edge
    relock_pulse();
    wait_phase(M_STAB, 50);
    cyc(5);
    locked = 1'b0; cyc(3);
    locked = 1'b1;
    seen = 0; n = 0;
    do begin cyc(1); n++; seen |= pll_rst; end while (sys_rst === 1'b1 && n < 100);
    check_eq("glitch_no_pll_rst", seen, 0);
    check_eq("glitch_relock_latency", n, 11);

    // force_relock in WAIT_LOCK is ignored
    relock_pulse();
    wait_phase(M_WAIT, 20);
    rc_before = int'(relock_cnt);
    relock_pulse();
    wait_run(50);
    check_eq("force_in_wait_ignored", relock_cnt, rc_before);

    // Saturation
    for (int i = 0; i < 300; i++) begin
      wait_run(50);
      relock_pulse();
    end
    wait_run(50);
    check_eq("relock_saturated", relock_cnt, 255);

    // Randomized lock behaviour and requests
    for (int i = 0; i < 2500; i++) begin
      if (locked) locked = ($urandom_range(0, 99) >= 2);
      else        locked = ($urandom_range(0, 99) < 12);
      force_relock = ($urandom_range(0, 49) == 0);
      cyc(1);
    end
    force_relock = 1'b0;
    locked = 1'b1;
    wait_run(200);

    // Asynchronous reset mid-STABILIZE
    relock_pulse();
    wait_phase(M_STAB, 50);
    cyc(3);
    #3 rst = 1'b1;
    #1;
    model_reset();
    check_eq("async_pll_rst", pll_rst, 1);
    check_eq("async_sys_rst", sys_rst, 1);
    check_eq("async_relock", relock_cnt, 0);
    check_eq("async_pll_ok", pll_ok, 0);
    cyc(2);
    rst = 1'b0;
    wait_run(100);

    $display("TB_RESULT checks=%0d failures=%0d", chk_cnt, err_cnt);
    $finish;
  end

endmodule
